// File: rtl/ripple_count_capture.sv
`default_nettype none
// ============================================================================
// Module      : ripple_count_capture
// Description : Synchronizes and filters a ripple counter output, extends it
//               to a wrap-aware wide count and reports changes as events.
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_count_capture #(
    parameter int IN_W   = 4,
    parameter int EXT_W  = 16,
    parameter int STABLE = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IN_W-1:0]    cnt_in,
    input  logic               clr,
    output logic [EXT_W-1:0]   ext_count,
    output logic [IN_W-1:0]    acc_val,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [IN_W+1:0]    evt_delta,
    output logic               evt_wrap,
    output logic               overrun,
    output logic               ext_ovf
);

    localparam logic [3:0] c_STABLE  = 4'(STABLE);
    localparam logic [3:0] c_CNT_MAX = 4'hF;

    logic [IN_W-1:0]  r_s1;
    logic [IN_W-1:0]  r_s2;
    logic [3:0]       r_stab_cnt;
    logic [IN_W-1:0]  r_acc;
    logic [EXT_W-1:0] r_ext;
    logic             r_evt_valid;
    logic [IN_W+1:0]  r_evt_delta;
    logic             r_evt_wrap;
    logic             r_overrun;
    logic             r_ext_ovf;

    logic             w_accept;
    logic [IN_W-1:0]  w_delta;
    logic             w_wrap;
    logic [EXT_W:0]   w_ext_sum;
    logic [IN_W+2:0]  w_merge_sum;
    logic [IN_W+1:0]  w_merge_sat;
    logic             w_xfer;

    // Stability count is taken from registered state, which gives the
    // extra edge of latency between reaching STABLE and acceptance.
    assign w_accept    = (r_stab_cnt == c_STABLE) && (r_s2 != r_acc);
    assign w_delta     = r_s2 - r_acc;
    assign w_wrap      = (r_s2 < r_acc);
    assign w_ext_sum   = {1'b0, r_ext} + {{(EXT_W+1-IN_W){1'b0}}, w_delta};
    assign w_merge_sum = {1'b0, r_evt_delta} + {3'b000, w_delta};
    assign w_merge_sat = w_merge_sum[IN_W+2] ? '1 : w_merge_sum[IN_W+1:0];
    assign w_xfer      = r_evt_valid && evt_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_stab_cnt <= '0;
        end else begin
            r_s1 <= cnt_in;
            r_s2 <= r_s1;
            if (clr || (r_s1 != r_s2)) begin
                r_stab_cnt <= 4'd1;
            end else if (r_stab_cnt != c_CNT_MAX) begin
                r_stab_cnt <= r_stab_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_ext       <= '0;
            r_evt_valid <= 1'b0;
            r_evt_delta <= '0;
            r_evt_wrap  <= 1'b0;
            r_overrun   <= 1'b0;
            r_ext_ovf   <= 1'b0;
        end else if (clr) begin
            r_acc       <= r_s2;
            r_ext       <= '0;
            r_evt_valid <= 1'b0;
            r_evt_delta <= '0;
            r_evt_wrap  <= 1'b0;
            r_overrun   <= 1'b0;
            r_ext_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_acc <= r_s2;
            r_ext <= w_ext_sum[EXT_W-1:0];
            if (w_ext_sum[EXT_W]) begin
                r_ext_ovf <= 1'b1;
            end
            if (!r_evt_valid || evt_ready) begin
                r_evt_valid <= 1'b1;
                r_evt_delta <= {2'b00, w_delta};
                r_evt_wrap  <= w_wrap;
            end else begin
                // Consumer stalled: fold this change into the pending event.
                r_overrun   <= 1'b1;
                r_evt_delta <= w_merge_sat;
                r_evt_wrap  <= r_evt_wrap | w_wrap;
            end
        end else if (w_xfer) begin
            r_evt_valid <= 1'b0;
        end
    end

    assign ext_count = r_ext;
    assign acc_val   = r_acc;
    assign evt_valid = r_evt_valid;
    assign evt_delta = r_evt_delta;
    assign evt_wrap  = r_evt_wrap;
    assign overrun   = r_overrun;
    assign ext_ovf   = r_ext_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ripple_count_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_ripple_count_capture
// Description : Directed self-checking bench for ripple_count_capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ripple_count_capture;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        clr       = 1'b0;
    logic        evt_ready = 1'b1;
    logic [3:0]  cnt_in    = 4'd0;

    logic [15:0] ext_count;
    logic [3:0]  acc_val;
    logic        evt_valid;
    logic [5:0]  evt_delta;
    logic        evt_wrap;
    logic        overrun;
    logic        ext_ovf;

    logic [4:0]  ext5;
    logic [3:0]  acc5;
    logic        valid5;
    logic [5:0]  delta5;
    logic        wrap5;
    logic        overrun5;
    logic        ovf5;

    int n_checks = 0;
    int n_fail   = 0;

    ripple_count_capture #(.IN_W(4), .EXT_W(16), .STABLE(2)) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr(clr),
        .ext_count(ext_count), .acc_val(acc_val), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_delta(evt_delta), .evt_wrap(evt_wrap),
        .overrun(overrun), .ext_ovf(ext_ovf)
    );

    ripple_count_capture #(.IN_W(4), .EXT_W(5), .STABLE(2)) dut5 (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .clr(clr),
        .ext_count(ext5), .acc_val(acc5), .evt_valid(valid5),
        .evt_ready(evt_ready), .evt_delta(delta5), .evt_wrap(wrap5),
        .overrun(overrun5), .ext_ovf(ovf5)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cnt_in = 4'd0;
        #2;
        n_checks++;
        if ({ext_count, acc_val, evt_valid, evt_delta, evt_wrap, overrun, ext_ovf} !== 30'd0) begin
            $display("FAIL reset_outputs: got %h expected 0",
                     {ext_count, acc_val, evt_valid, evt_delta, evt_wrap, overrun, ext_ovf});
            n_fail++;
        end
        cyc(2);
        rst = 1'b0;
        cyc(6);
        n_checks++;
        if (ext_count !== 16'd0 || evt_valid !== 1'b0) begin
            $display("FAIL reset_idle: got ext=%0d valid=%0d expected 0 0", ext_count, evt_valid);
            n_fail++;
        end
    endtask

    task automatic test_steady();
        for (int v = 1; v <= 3; v++) begin
            cnt_in = 4'(v);
            cyc(3);
            n_checks++;
            if (ext_count !== 16'(v - 1)) begin
                $display("FAIL steady_early: got %0d expected %0d", ext_count, v - 1);
                n_fail++;
            end
            cyc(1);
            n_checks++;
            if (ext_count !== 16'(v) || acc_val !== 4'(v) || evt_valid !== 1'b1 ||
                evt_delta !== 6'd1 || evt_wrap !== 1'b0) begin
                $display("FAIL steady_update: got ext=%0d acc=%0d valid=%0d delta=%0d wrap=%0d expected %0d %0d 1 1 0",
                         ext_count, acc_val, evt_valid, evt_delta, evt_wrap, v, v);
                n_fail++;
            end
            cyc(1);
            n_checks++;
            if (evt_valid !== 1'b0) begin
                $display("FAIL steady_xfer: got valid=%0d expected 0", evt_valid);
                n_fail++;
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] seq [3] = '{4'd6, 4'd4, 4'd0};
        int ev_n = 0;
        logic [5:0] ev_d = '0;
        logic ev_w = 1'b0;
        cnt_in = 4'd7;
        cyc(6);
        n_checks++;
        if (ext_count !== 16'd7 || acc_val !== 4'd7) begin
            $display("FAIL glitch_setup: got ext=%0d acc=%0d expected 7 7", ext_count, acc_val);
            n_fail++;
        end
        for (int i = 0; i < 3; i++) begin
            cnt_in = seq[i];
            cyc(1);
            if (evt_valid) begin ev_n++; ev_d = evt_delta; ev_w = evt_wrap; end
        end
        cnt_in = 4'd8;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (evt_valid) begin ev_n++; ev_d = evt_delta; ev_w = evt_wrap; end
        end
        n_checks++;
        if (ev_n !== 1 || ev_d !== 6'd1 || ev_w !== 1'b0) begin
            $display("FAIL glitch_events: got n=%0d delta=%0d wrap=%0d expected 1 1 0", ev_n, ev_d, ev_w);
            n_fail++;
        end
        n_checks++;
        if (ext_count !== 16'd8 || acc_val !== 4'd8) begin
            $display("FAIL glitch_total: got ext=%0d acc=%0d expected 8 8", ext_count, acc_val);
            n_fail++;
        end
    endtask

    task automatic test_wrap();
        logic [3:0] vals [3] = '{4'd15, 4'd0, 4'd1};
        logic       wraps[3] = '{1'b0, 1'b1, 1'b0};
        cnt_in = 4'd14;
        cyc(6);
        for (int i = 0; i < 3; i++) begin
            cnt_in = vals[i];
            cyc(4);
            n_checks++;
            if (evt_valid !== 1'b1 || evt_delta !== 6'd1 || evt_wrap !== wraps[i]) begin
                $display("FAIL wrap_event: value %0d got valid=%0d delta=%0d wrap=%0d expected 1 1 %0d",
                         vals[i], evt_valid, evt_delta, evt_wrap, wraps[i]);
                n_fail++;
            end
            cyc(1);
        end
        n_checks++;
        if (ext_count !== 16'd17 || acc_val !== 4'd1) begin
            $display("FAIL wrap_total: got ext=%0d acc=%0d expected 17 1", ext_count, acc_val);
            n_fail++;
        end
    endtask

    task automatic test_stall();
        logic [3:0] vals [5] = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd15};
        evt_ready = 1'b0;
        for (int v = 2; v <= 4; v++) begin
            cnt_in = 4'(v);
            cyc(5);
        end
        n_checks++;
        if (evt_valid !== 1'b1 || evt_delta !== 6'd3 || overrun !== 1'b1 ||
            evt_wrap !== 1'b0 || ext_count !== 16'd20) begin
            $display("FAIL stall_merge: got valid=%0d delta=%0d ovr=%0d wrap=%0d ext=%0d expected 1 3 1 0 20",
                     evt_valid, evt_delta, overrun, evt_wrap, ext_count);
            n_fail++;
        end
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        n_checks++;
        if (evt_valid !== 1'b0 || overrun !== 1'b1 || evt_delta !== 6'd3) begin
            $display("FAIL stall_release: got valid=%0d ovr=%0d delta=%0d expected 0 1 3",
                     evt_valid, overrun, evt_delta);
            n_fail++;
        end
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0 || ext_count !== 16'd0 || evt_valid !== 1'b0 || acc_val !== 4'd4) begin
            $display("FAIL stall_clr: got ovr=%0d ext=%0d valid=%0d acc=%0d expected 0 0 0 4",
                     overrun, ext_count, evt_valid, acc_val);
            n_fail++;
        end
        // Five deltas of 15 overflow the 6-bit event delta.
        for (int i = 0; i < 5; i++) begin
            cnt_in = vals[i];
            cyc(5);
        end
        n_checks++;
        if (evt_delta !== 6'd63 || evt_wrap !== 1'b1 || overrun !== 1'b1 || ext_count !== 16'd75) begin
            $display("FAIL stall_saturate: got delta=%0d wrap=%0d ovr=%0d ext=%0d expected 63 1 1 75",
                     evt_delta, evt_wrap, overrun, ext_count);
            n_fail++;
        end
        evt_ready = 1'b1;
        cyc(1);
        n_checks++;
        if (evt_valid !== 1'b0) begin
            $display("FAIL stall_drain: got valid=%0d expected 0", evt_valid);
            n_fail++;
        end
    endtask

    task automatic test_ext_ovf();
        int ev_n = 0;
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            cnt_in = cnt_in + 4'd1;
            cyc(5);
            if (i == 31) begin
                n_checks++;
                if (ext5 !== 5'd31 || ovf5 !== 1'b0) begin
                    $display("FAIL ovf_before: got ext=%0d ovf=%0d expected 31 0", ext5, ovf5);
                    n_fail++;
                end
            end
        end
        n_checks++;
        if (ext5 !== 5'd0 || ovf5 !== 1'b1) begin
            $display("FAIL ovf_wrap: got ext=%0d ovf=%0d expected 0 1", ext5, ovf5);
            n_fail++;
        end
        n_checks++;
        if (ext_count !== 16'd32 || ext_ovf !== 1'b0) begin
            $display("FAIL ovf_wide: got ext=%0d ovf=%0d expected 32 0", ext_count, ext_ovf);
            n_fail++;
        end
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (valid5) ev_n++;
            cyc(1);
        end
        n_checks++;
        if (ext5 !== 5'd0 || ovf5 !== 1'b0 || ev_n !== 0) begin
            $display("FAIL ovf_clr: got ext=%0d ovf=%0d events=%0d expected 0 0 0", ext5, ovf5, ev_n);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        int ev_n = 0;
        logic [5:0] ev_d = '0;
        evt_ready = 1'b0;
        cnt_in = cnt_in + 4'd1;
        cyc(5);
        n_checks++;
        if (evt_valid !== 1'b1) begin
            $display("FAIL arst_pending: got valid=%0d expected 1", evt_valid);
            n_fail++;
        end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ext_count, acc_val, evt_valid, evt_delta, evt_wrap, overrun, ext_ovf} !== 30'd0) begin
            $display("FAIL arst_clear: got %h expected 0",
                     {ext_count, acc_val, evt_valid, evt_delta, evt_wrap, overrun, ext_ovf});
            n_fail++;
        end
        cnt_in = 4'd5;
        evt_ready = 1'b1;
        cyc(2);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (evt_valid) begin ev_n++; ev_d = evt_delta; end
        end
        n_checks++;
        if (ev_n !== 1 || ev_d !== 6'd5 || ext_count !== 16'd5) begin
            $display("FAIL arst_restart: got n=%0d delta=%0d ext=%0d expected 1 5 5", ev_n, ev_d, ext_count);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_glitch();
        test_wrap();
        test_stall();
        test_ext_ovf();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ripple_count_capture.md
Name: ripple_count_capture

Overview:
- Consumer stage for a 4-bit asynchronous ripple counter output.
- Samples the glitchy, skewed ripple count into the system clock domain through a two-flop synchronizer.
- Filters transient intermediate codes and extends the count to a wide, wrap-aware total.
- Reports each accepted change on a valid/ready event interface for downstream logic.

Parameters:
- IN_W, 4: width of the ripple count input.
- EXT_W, 16: width of the extended count output. Must be greater than IN_W.
- STABLE, 2: consecutive clk edges a synchronized value must hold before acceptance. Legal range 1..15.

Ports:
- clk, input, 1: system clock. Rising edge.
- rst, input, 1: asynchronous, active-high reset.
- cnt_in, input, IN_W: ripple counter output. Asynchronous to clk.
- clr, input, 1: synchronous clear of the accumulated state.
- ext_count, output, EXT_W: extended accumulated count.
- acc_val, output, IN_W: last accepted filtered input value.
- evt_valid, output, 1: event pending.
- evt_ready, input, 1: consumer accepts the event.
- evt_delta, output, IN_W+2: count increment carried by the pending event.
- evt_wrap, output, 1: the pending event included an input wrap (new value < previous value).
- overrun, output, 1: sticky flag; an event was merged because the consumer stalled.
- ext_ovf, output, 1: sticky flag; ext_count wrapped past 2^EXT_W-1.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: takes effect immediately, independent of clk. All of the following clear to 0: sync flops, stability counter, acc_val, ext_count, evt_valid, evt_delta, evt_wrap, overrun, ext_ovf.
- Synchronizer: s1 <= cnt_in, s2 <= s1. No logic between s1 and s2.
- Stability filter:
  - A stability counter counts consecutive edges for which s2 holds the same value. The edge at which s2 loads the value counts as 1.
  - The counter restarts at 1 whenever s2 changes.
  - When the count reaches STABLE and s2 != acc_val, the value is accepted.
  - Latency: if cnt_in settles to a new value before edge k, ext_count, acc_val and evt_valid update at edge k+STABLE+1. For STABLE=2 that is edge k+3.
  - Any value s2 holds for fewer than STABLE edges is ignored. Ripple glitch codes must never be accepted.
- Accept (new value N, previous acc_val A):
  - delta = (N - A) mod 2^IN_W. delta is never 0.
  - acc_val <= N.
  - ext_count <= (ext_count + delta) mod 2^EXT_W.
  - If the addition carries out of EXT_W bits, ext_ovf <= 1.
  - wrap = (N < A).
- Event interface:
  - Transfer occurs when evt_valid && evt_ready.
  - Accept with no event pending, or with a transfer in the same cycle: evt_valid <= 1, evt_delta <= delta, evt_wrap <= wrap. No overrun.
  - Accept while pending with evt_ready=0: overrun <= 1, evt_delta <= evt_delta + delta (saturating at 2^(IN_W+2)-1), evt_wrap <= evt_wrap | wrap. evt_valid stays 1.
  - Transfer with no accept: evt_valid <= 0. evt_delta and evt_wrap hold their last values.
  - evt_delta and evt_wrap must not change while evt_valid=1 except on a merge.
- clr (synchronous):
  - Clears ext_count, evt_valid, evt_delta, evt_wrap, overrun, ext_ovf.
  - Sets acc_val <= s2, so the current input produces no event.
  - Restarts the stability counter.
  - clr has priority over an accept in the same cycle; that accept is discarded.
- Overflow flags: overrun and ext_ovf are cleared only by rst or clr.

Test Plan:
- Reset then steady count: hold cnt_in=0. Step to 1, 2, 3, each held 5 cycles, STABLE=2. Required: ext_count steps 1, 2, 3; each update lands 3 edges after the first sampling edge; evt_delta=1 each time; evt_ready=1 throughout.
- Glitch rejection: cnt_in goes 7 -> 6 -> 4 -> 0 -> 8, each intermediate held 1 cycle, then 8 held. Required: exactly one event with evt_delta=1 (7 -> 8) and evt_wrap=0.
- Input wrap: acc_val=14. Drive 15, then 0, then 1. Required: ext_count advances by 3; the event for 0 has evt_wrap=1 and evt_delta=1.
- Stall and merge: evt_ready=0 for three accepts of +1 each. Required: evt_valid=1, evt_delta=3, overrun=1. Raise evt_ready for one cycle: evt_valid drops next edge; overrun stays 1.
- Extended overflow: EXT_W=5, step the input through 32 increments. Required: ext_count returns to 0 and ext_ovf=1. clr then zeroes ext_count and ext_ovf and generates no event.
- Async reset mid-event: assert rst between clock edges while evt_valid=1. Required: all outputs are 0 before the next edge. After release with cnt_in=5, one event with evt_delta=5.
